mult_cmd_dispatcher: RTL and testbench

//  Sits directly downstream of the command FIFO in the sequential multiplier path. It pops
//  one 4-bit command at a time and decodes it. It then issues a start pulse to the field

---
 rtl/mult_cmd_dispatcher.sv | 145 ++++++++++++++
 tb/tb_mult_cmd_dispatcher.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_cmd_dispatcher.sv
// Command dispatcher between the command FIFO and the field multiplier.
// Pops one command at a time, decodes it, starts the multiplier for MUL/SQR
// and waits for completion, while keeping a completed-command count and
// sticky illegal-opcode / timeout flags.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  S_IDLE  | waiting for enable and a non-empty FIFO
//  S_FETCH | read strobe to FIFO, data appears on the following edge
//  S_LATCH | decode the FIFO word: NOP, illegal or multiplier command
//  S_ISSUE | one-cycle start pulse to the multiplier, timer cleared
//  S_WAIT  | waiting for mult_done or for the timeout to expire
module mult_cmd_dispatcher #(
    parameter int DATA    = 4,
    parameter int CNT_W   = 8,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_en_o,
    input  logic [DATA-1:0]  fifo_data_i,
    output logic             mult_start_o,
    output logic [1:0]       mult_op_o,
    output logic [1:0]       mult_dst_o,
    input  logic             mult_done_i,
    input  logic             err_clr_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] cmd_count_o,
    output logic             err_illegal_o,
    output logic             err_timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    localparam logic [1:0]      OP_NOP  = 2'b00;
    localparam logic [1:0]      OP_ILL  = 2'b11;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]    tmr_q, tmr_d;
    logic [1:0]         op_q, op_d;
    logic [1:0]         dst_q, dst_d;
    logic               ill_q, ill_d;
    logic               to_q, to_d;
    logic               ill_set, to_set;

    logic [1:0] opcode;
    logic [1:0] dst_idx;
    assign opcode  = fifo_data_i[3:2];
    assign dst_idx = fifo_data_i[1:0];

    // State and datapath registers; reset drops any in-flight command
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
            op_q    <= 2'b00;
            dst_q   <= 2'b00;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            ill_q   <= ill_d;
            to_q    <= to_d;
        end
    end

    // Next-state logic; mult_done takes priority over an expiring timer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable_i && !fifo_empty_i) state_d = S_FETCH;
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                if (opcode == OP_NOP || opcode == OP_ILL) state_d = S_IDLE;
                else                                      state_d = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mult_done_i || tmr_q == TO_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter, timer, command hold registers and sticky error flags
    always_comb begin
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        op_d    = op_q;
        dst_d   = dst_q;
        ill_set = 1'b0;
        to_set  = 1'b0;
        case (state_q)
            S_LATCH: begin
                if (opcode == OP_NOP) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (opcode == OP_ILL) begin
                    ill_set = 1'b1;
                end else begin
                    op_d  = opcode;
                    dst_d = dst_idx;
                end
            end
            S_ISSUE: tmr_d = '0;
            S_WAIT: begin
                if (mult_done_i)            cnt_d  = cnt_q + CNT_W'(1);
                else if (tmr_q == TO_LAST)  to_set = 1'b1;
                else                        tmr_d  = tmr_q + TO_W'(1);
            end
            default: ;
        endcase
        // a flag being set in the same cycle as err_clr stays set
        ill_d = ill_set | (ill_q & ~err_clr_i);
        to_d  = to_set  | (to_q  & ~err_clr_i);
    end

    // Moore outputs decoded from state or driven from registers
    always_comb begin
        fifo_rd_en_o  = (state_q == S_FETCH);
        mult_start_o  = (state_q == S_ISSUE);
        busy_o        = (state_q != S_IDLE);
        mult_op_o     = op_q;
        mult_dst_o    = dst_q;
        cmd_count_o   = cnt_q;
        err_illegal_o = ill_q;
        err_timeout_o = to_q;
    end

endmodule

// File: tb/tb_mult_cmd_dispatcher.sv
// Bench for mult_cmd_dispatcher: two instances (8-bit and 2-bit command
// counters) share one FIFO model and are compared every cycle against a
// command-level behavioural model, plus directed literal expectations.
module tb_mult_cmd_dispatcher;

    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       rst, enable, fifo_empty, mult_done, err_clr;
    logic [3:0] fifo_data;

    logic       rd_a, start_a, busy_a, ill_a, to_a;
    logic [1:0] op_a, dst_a;
    logic [7:0] cnt_a;
    logic       rd_b, start_b, busy_b, ill_b, to_b;
    logic [1:0] op_b, dst_b;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    mult_cmd_dispatcher #(.DATA(4), .CNT_W(8), .TO_W(8), .TIMEOUT(TIMEOUT)) dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .fifo_empty_i(fifo_empty),
        .fifo_rd_en_o(rd_a), .fifo_data_i(fifo_data), .mult_start_o(start_a),
        .mult_op_o(op_a), .mult_dst_o(dst_a), .mult_done_i(mult_done),
        .err_clr_i(err_clr), .busy_o(busy_a), .cmd_count_o(cnt_a),
        .err_illegal_o(ill_a), .err_timeout_o(to_a));

    mult_cmd_dispatcher #(.DATA(4), .CNT_W(2), .TO_W(8), .TIMEOUT(TIMEOUT)) dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .fifo_empty_i(fifo_empty),
        .fifo_rd_en_o(rd_b), .fifo_data_i(fifo_data), .mult_start_o(start_b),
        .mult_op_o(op_b), .mult_dst_o(dst_b), .mult_done_i(mult_done),
        .err_clr_i(err_clr), .busy_o(busy_b), .cmd_count_o(cnt_b),
        .err_illegal_o(ill_b), .err_timeout_o(to_b));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO model and event bookkeeping
    logic [3:0] fifo_q[$];
    int cyc = 0;
    int rd_pulses = 0, st_pulses = 0;
    int rd_cyc = 0, st_cyc = 0, idle_cyc = 0;
    logic prev_busy = 1'b0;

    // Behavioural model: a command is "active" from fetch onward and its
    // age counts cycles since the fetch (0 fetch, 1 decode, 2 start, 3+ waiting)
    bit m_valid = 1'b0;
    bit m_active = 1'b0;
    int m_age = 0;
    int m_count = 0;
    bit m_ill = 1'b0, m_to = 1'b0;
    int m_op = 0, m_dst = 0;
    bit set_ill, set_to;

    always @(negedge clk) begin
        cyc++;
        if (m_valid) begin
            check("rd_en_a",   rd_a,    m_active && m_age == 0);
            check("start_a",   start_a, m_active && m_age == 2);
            check("busy_a",    busy_a,  m_active);
            check("op_a",      op_a,    m_op);
            check("dst_a",     dst_a,   m_dst);
            check("count_a",   cnt_a,   m_count % 256);
            check("illegal_a", ill_a,   m_ill);
            check("timeout_a", to_a,    m_to);
            check("rd_en_b",   rd_b,    m_active && m_age == 0);
            check("start_b",   start_b, m_active && m_age == 2);
            check("busy_b",    busy_b,  m_active);
            check("op_b",      op_b,    m_op);
            check("dst_b",     dst_b,   m_dst);
            check("count_b",   cnt_b,   m_count % 4);
            check("illegal_b", ill_b,   m_ill);
            check("timeout_b", to_b,    m_to);
        end
        if (rd_a === 1'b1) begin
            rd_pulses++;
            rd_cyc = cyc;
            check("read_nonempty", fifo_q.size() > 0, 1);
            if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        end
        if (start_a === 1'b1) begin
            st_pulses++;
            st_cyc = cyc;
        end
        if (prev_busy === 1'b1 && busy_a === 1'b0) idle_cyc = cyc;
        prev_busy = busy_a;
        fifo_empty = (fifo_q.size() == 0);

        set_ill = 1'b0;
        set_to  = 1'b0;
        if (rst) begin
            m_valid = 1'b1; m_active = 1'b0; m_age = 0; m_count = 0;
            m_ill = 1'b0; m_to = 1'b0; m_op = 0; m_dst = 0;
        end else if (m_valid) begin
            if (!m_active) begin
                if (enable && !fifo_empty) begin m_active = 1'b1; m_age = 0; end
            end else if (m_age == 1) begin
                case (fifo_data[3:2])
                    2'b00: begin m_count++; m_active = 1'b0; end
                    2'b11: begin set_ill = 1'b1; m_active = 1'b0; end
                    default: begin m_op = fifo_data[3:2]; m_dst = fifo_data[1:0]; m_age++; end
                endcase
            end else if (m_age >= 3) begin
                if (mult_done) begin m_count++; m_active = 1'b0; end
                else if (m_age - 3 == TIMEOUT - 1) begin set_to = 1'b1; m_active = 1'b0; end
                else m_age++;
            end else begin
                m_age++;
            end
            m_ill = set_ill ? 1'b1 : (err_clr ? 1'b0 : m_ill);
            m_to  = set_to  ? 1'b1 : (err_clr ? 1'b0 : m_to);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string name, input int budget);
        int n = 0;
        while (start_a !== 1'b1 && n < budget) begin tick(); n++; end
        check(name, start_a, 1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy_a !== 1'b0 && n < budget) begin tick(); n++; end
        check(name, busy_a, 0);
    endtask

    int push_cyc;
    int wrap_exp[5] = '{1, 2, 3, 0, 1};

    initial begin
        rst = 1'b1; enable = 1'b0; mult_done = 1'b0; err_clr = 1'b0;
        fifo_data = 4'b0000; fifo_empty = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_busy", busy_a, 0);
        check("reset_count", cnt_a, 0);
        check("reset_op", op_a, 0);

        // 1: single MUL dst 2
        enable = 1'b1; rd_pulses = 0; st_pulses = 0;
        push_cyc = cyc;
        fifo_q.push_back(4'b0110);
        wait_start("t1_start_seen", 20);
        repeat (9) tick();
        mult_done = 1'b1; tick(); mult_done = 1'b0;
        wait_idle("t1_idle", 20);
        tick();
        check("t1_rd_latency", rd_cyc - push_cyc, 2);
        check("t1_start_latency", st_cyc - rd_cyc, 2);
        check("t1_op", op_a, 1);
        check("t1_dst", dst_a, 2);
        check("t1_count", cnt_a, 1);
        check("t1_rd_pulses", rd_pulses, 1);
        check("t1_start_pulses", st_pulses, 1);

        // 2: NOP then SQR dst 1
        rd_pulses = 0; st_pulses = 0;
        fifo_q.push_back(4'b0000);
        fifo_q.push_back(4'b1001);
        wait_start("t2_start_seen", 30);
        check("t2_op", op_a, 2);
        check("t2_dst", dst_a, 1);
        check("t2_count_after_nop", cnt_a, 2);
        repeat (3) tick();
        mult_done = 1'b1; tick(); mult_done = 1'b0;
        tick();
        check("t2_count", cnt_a, 3);
        check("t2_rd_pulses", rd_pulses, 2);
        check("t2_start_pulses", st_pulses, 1);

        // 3: illegal opcode, clear, then set-vs-clear collision
        st_pulses = 0;
        fifo_q.push_back(4'b1111);
        repeat (6) tick();
        check("t3_illegal", ill_a, 1);
        check("t3_count", cnt_a, 3);
        check("t3_no_start", st_pulses, 0);
        check("t3_op_held", op_a, 2);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("t3_cleared", ill_a, 0);
        err_clr = 1'b1;
        fifo_q.push_back(4'b1100);
        repeat (6) tick();
        err_clr = 1'b0;
        tick();

        // 4: timeout, then done on the last allowed WAIT cycle
        fifo_q.push_back(4'b0100);
        wait_start("t4_start_seen", 20);
        wait_idle("t4_idle", 300);
        tick();
        check("t4_timeout", to_a, 1);
        check("t4_count", cnt_a, 3);
        check("t4_wait_len", idle_cyc - st_cyc, TIMEOUT + 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("t4_cleared", to_a, 0);
        fifo_q.push_back(4'b1000);
        wait_start("t4b_start_seen", 20);
        repeat (TIMEOUT) tick();
        mult_done = 1'b1; tick(); mult_done = 1'b0;
        tick();
        check("t4b_count", cnt_a, 4);
        check("t4b_timeout", to_a, 0);
        check("t4b_busy", busy_a, 0);

        // 5: reset during WAIT, stray done, enable gating
        fifo_q.push_back(4'b0101);
        wait_start("t5_start_seen", 20);
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_rst_busy", busy_a, 0);
        check("t5_rst_op", op_a, 0);
        check("t5_rst_dst", dst_a, 0);
        check("t5_rst_count", cnt_a, 0);
        mult_done = 1'b1; tick(); mult_done = 1'b0;
        tick();
        check("t5_done_ignored", cnt_a, 0);
        enable = 1'b0; rd_pulses = 0;
        fifo_q.push_back(4'b0000);
        repeat (10) tick();
        check("t5_enable_blocks", rd_pulses, 0);
        enable = 1'b1;
        repeat (6) tick();
        check("t5_enable_resumes", rd_pulses, 1);
        check("t5_count", cnt_a, 1);

        // 6: 2-bit counter wrap over five NOPs
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fifo_q.push_back(4'b0000);
            repeat (5) tick();
            check("t6_wrap", cnt_b, wrap_exp[i]);
            check("t6_count8", cnt_a, i + 1);
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got time %0t expected < 200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
